// File: rtl/mem_wr_port_arbiter_pkg.sv
// Shared MCB constants and arbiter state encoding for the write-port arbiter.
package mem_wr_port_arbiter_pkg;
  localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
  localparam int MCB_ADDR_BITS = 30;
  localparam int MCB_BL_BITS   = 6;
  localparam int MCB_DATA_BITS = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_CMD   = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;
endpackage

// File: rtl/mem_wr_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the requester that did not win last goes next.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       sel,
  output logic       valid
);
  always_comb begin
    valid = |req;
    sel   = req[1];
    if (&req) sel = ~last_winner;
  end
endmodule

// File: rtl/mem_wr_port_arbiter.sv
// Shares one write-only MCB user port between two burst writers, one transaction at a time.
module mem_wr_port_arbiter
  import mem_wr_port_arbiter_pkg::*;
#(
  parameter int DATA_BITS = MCB_DATA_BITS,
  parameter int MASK_BITS = DATA_BITS / 8,
  parameter int ADDR_BITS = MCB_ADDR_BITS,
  parameter int BL_BITS   = MCB_BL_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 calib_done,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [BL_BITS-1:0]   bl0,
  input  logic [BL_BITS-1:0]   bl1,
  input  logic [DATA_BITS-1:0] wdata0,
  input  logic [DATA_BITS-1:0] wdata1,
  input  logic [MASK_BITS-1:0] wmask0,
  input  logic [MASK_BITS-1:0] wmask1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic                 mem_cmd_en,
  output logic [2:0]           mem_cmd_instr,
  output logic [BL_BITS-1:0]   mem_cmd_bl,
  output logic [ADDR_BITS-1:0] mem_cmd_byte_addr,
  input  logic                 mem_cmd_full,
  output logic                 mem_wr_en,
  output logic [DATA_BITS-1:0] mem_wr_data,
  output logic [MASK_BITS-1:0] mem_wr_mask,
  input  logic                 mem_wr_full,
  input  logic                 mem_wr_underrun,
  input  logic                 mem_wr_error,
  output logic                 err
);
  logic [1:0]                  req_v;
  logic [1:0][DATA_BITS-1:0]   wdata_v;
  logic [1:0][MASK_BITS-1:0]   wmask_v;
  logic [1:0][ADDR_BITS-1:0]   addr_v;
  logic [1:0][BL_BITS-1:0]     bl_v;

  assign req_v   = {req1, req0};
  assign wdata_v = {wdata1, wdata0};
  assign wmask_v = {wmask1, wmask0};
  assign addr_v  = {addr1, addr0};
  assign bl_v    = {bl1, bl0};

  arb_state_e           state_q, state_d;
  logic                 sel_q, last_winner_q, err_q;
  logic [BL_BITS-1:0]   cnt_q, bl_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 arb_sel, arb_valid;
  logic                 grant, wr_acc, cmd_acc;

  rr_arb2 u_arb (
    .req         (req_v),
    .last_winner (last_winner_q),
    .sel         (arb_sel),
    .valid       (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    wr_acc  = 1'b0;
    cmd_acc = 1'b0;
    case (state_q)
      ARB_IDLE: if (calib_done && arb_valid) begin
        grant   = 1'b1;
        state_d = ARB_WRITE;
      end
      ARB_WRITE: begin
        wr_acc = !mem_wr_full;
        if (wr_acc && cnt_q == bl_q) state_d = ARB_CMD;
      end
      // Command only after every data word is in the FIFO.
      ARB_CMD: begin
        cmd_acc = !mem_cmd_full;
        if (cmd_acc) state_d = ARB_DONE;
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      sel_q         <= 1'b0;
      last_winner_q <= 1'b1;
      cnt_q         <= '0;
      bl_q          <= '0;
      addr_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | mem_wr_underrun | mem_wr_error;
      if (grant) begin
        sel_q  <= arb_sel;
        bl_q   <= bl_v[arb_sel];
        addr_q <= addr_v[arb_sel];
        cnt_q  <= '0;
      end
      if (wr_acc) cnt_q <= cnt_q + 1'b1;
      if (state_q == ARB_DONE) last_winner_q <= sel_q;
    end
  end

  logic owned, in_write, in_done;
  assign owned    = (state_q == ARB_WRITE) || (state_q == ARB_CMD);
  assign in_write = (state_q == ARB_WRITE);
  assign in_done  = (state_q == ARB_DONE);

  assign gnt0  = owned & ~sel_q;
  assign gnt1  = owned &  sel_q;
  assign ack0  = wr_acc & ~sel_q;
  assign ack1  = wr_acc &  sel_q;
  assign done0 = in_done & ~sel_q;
  assign done1 = in_done &  sel_q;

  assign mem_cmd_en        = cmd_acc;
  assign mem_cmd_instr     = MCB_INSTR_WRITE;
  assign mem_cmd_bl        = bl_q;
  assign mem_cmd_byte_addr = addr_q;
  assign mem_wr_en         = wr_acc;
  // Data path follows the latched owner so a dropped req cannot redirect it.
  assign mem_wr_data       = in_write ? wdata_v[sel_q] : '0;
  assign mem_wr_mask       = in_write ? wmask_v[sel_q] : '0;
  assign err               = err_q;
endmodule
